// File: rtl/cntl_mc_hs.sv
//------------------------------------------------------------------------------
// cntl_mc_hs : multi-cycle RV32I/RV64I Moore control unit with memory handshake
// Optional build macro: ILLEGAL_TRAP_EN (trap illegal opcodes instead of NOP)
// Revision  : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cntl_mc_hs #(
  parameter int XLEN   = 32,
  parameter int MEM_TO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic            bcond,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_sel,
  output logic            mem_wr_en,
  output logic [1:0]      memory_size,
  output logic            mem_unsigned,
  output logic            load_ir,
  output logic            load_mdr,
  output logic            pc_update,
  output logic            reg_file_wr_en,
  output logic            wr_reg_mux_sel,
  output logic            op1_sel,
  output logic [1:0]      op2_sel,
  output logic [1:0]      alu_demux,
  output logic [4:0]      alu_ctrl,
  output logic [XLEN-1:0] immediate,
  output logic            illegal,
  output logic            mem_err,
  output logic [4:0]      curr_state
);

  localparam logic [4:0] S_FETCH    = 5'd0,  S_LOAD_IR  = 5'd1,  S_DECODE   = 5'd2;
  localparam logic [4:0] S_EXEC     = 5'd3,  S_ADDR     = 5'd4,  S_MEM      = 5'd5;
  localparam logic [4:0] S_LOAD_MDR = 5'd6,  S_LOAD_WR  = 5'd7,  S_WB       = 5'd8;
  localparam logic [4:0] S_BR_CMP   = 5'd9,  S_BR_TGT   = 5'd10, S_LINK     = 5'd11;
  localparam logic [4:0] S_LINK_WR  = 5'd12, S_JUMP_TGT = 5'd13, S_PC_ADD   = 5'd14;
  localparam logic [4:0] S_PC_WR    = 5'd15, S_TRAP     = 5'd16;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_STORE = 5'b01000, OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR = 5'b11001, OP_JAL   = 5'b11011, OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG  = 5'b01100, OP_LUI   = 5'b01101, OP_AUIPC  = 5'b00101;

  logic [4:0]  w_opcode;
  logic [2:0]  w_f3;
  logic        w_is_r, w_is_i, w_is_lui, w_is_auipc, w_is_load, w_is_store;
  logic        w_is_br, w_is_jal, w_is_jalr, w_legal;
  logic [4:0]  w_alu;
  logic [31:0] w_imm32;
  logic [4:0]  w_next_state;
  logic        w_wd_expire;

  assign w_opcode   = instruction[6:2];
  assign w_f3       = instruction[14:12];
  assign w_is_r     = (w_opcode == OP_REG);
  assign w_is_i     = (w_opcode == OP_IMM);
  assign w_is_lui   = (w_opcode == OP_LUI);
  assign w_is_auipc = (w_opcode == OP_AUIPC);
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_is_br    = (w_opcode == OP_BRANCH);
  assign w_is_jal   = (w_opcode == OP_JAL);
  assign w_is_jalr  = (w_opcode == OP_JALR);
  assign w_legal    = (instruction[1:0] == 2'b11) &&
                      (w_is_r || w_is_i || w_is_lui || w_is_auipc || w_is_load ||
                       w_is_store || w_is_br || w_is_jal || w_is_jalr);

  always_comb begin
    w_alu = 5'b00000;
    if (w_is_r)
      w_alu = {1'b0, instruction[30], w_f3};
    else if (w_is_i) begin
      if (w_f3 == 3'b010 || w_f3 == 3'b011) w_alu = {2'b01, w_f3};
      else if (w_f3 == 3'b101)             w_alu = {1'b0, instruction[30], w_f3};
      else                                 w_alu = {2'b00, w_f3};
    end
    else if (w_is_br)  w_alu = {2'b10, w_f3};
    else if (w_is_lui) w_alu = 5'b11000;
  end

  always_comb begin
    w_imm32 = 32'd0;
    if (w_is_i || w_is_load || w_is_jalr)
      w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
    else if (w_is_store)
      w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    else if (w_is_br)
      w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
    else if (w_is_lui || w_is_auipc)
      w_imm32 = {instruction[31:12], 12'd0};
    else if (w_is_jal)
      w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
  end

  // Completion has priority over watchdog expiry in the same cycle.
  always_comb begin
    w_next_state = curr_state;
    case (curr_state)
      S_FETCH:    w_next_state = mem_ready ? S_LOAD_IR : (w_wd_expire ? S_TRAP : S_FETCH);
      S_LOAD_IR:  w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_legal)
`ifdef ILLEGAL_TRAP_EN
          w_next_state = S_TRAP;
`else
          w_next_state = S_PC_ADD;
`endif
        else if (w_is_r || w_is_i || w_is_lui || w_is_auipc) w_next_state = S_EXEC;
        else if (w_is_load || w_is_store)                     w_next_state = S_ADDR;
        else if (w_is_br)                                     w_next_state = S_BR_CMP;
        else                                                  w_next_state = S_LINK;
      end
      S_EXEC:     w_next_state = S_WB;
      S_WB:       w_next_state = S_PC_ADD;
      S_ADDR:     w_next_state = S_MEM;
      S_MEM:      w_next_state = mem_ready ? (w_is_store ? S_PC_ADD : S_LOAD_MDR)
                                           : (w_wd_expire ? S_TRAP : S_MEM);
      S_LOAD_MDR: w_next_state = S_LOAD_WR;
      S_LOAD_WR:  w_next_state = S_PC_ADD;
      S_BR_CMP:   w_next_state = bcond ? S_BR_TGT : S_PC_ADD;
      S_BR_TGT:   w_next_state = S_PC_WR;
      S_LINK:     w_next_state = S_LINK_WR;
      S_LINK_WR:  w_next_state = S_JUMP_TGT;
      S_JUMP_TGT: w_next_state = S_PC_WR;
      S_PC_ADD:   w_next_state = S_PC_WR;
      S_PC_WR:    w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_FETCH;
    endcase
  end

  generate
    if (MEM_TO > 0) begin : g_wd
      localparam int WD_W = $clog2(MEM_TO + 1);
      logic [WD_W-1:0] r_wd_cnt;
      logic            w_waiting;
      assign w_waiting   = ((curr_state == S_FETCH) || (curr_state == S_MEM)) && !mem_ready;
      assign w_wd_expire = w_waiting && (r_wd_cnt == WD_W'(MEM_TO - 1));
      always_ff @(posedge clk) begin
        if (rst || (w_next_state != curr_state)) r_wd_cnt <= '0;
        else if (w_waiting)                      r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end else begin : g_no_wd
      assign w_wd_expire = 1'b0;
    end
  endgenerate

  // Strobes are decoded from the next state so they line up with curr_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      curr_state     <= S_FETCH;
      mem_req        <= 1'b1;
      {mem_sel, mem_wr_en, load_ir, load_mdr, pc_update} <= 5'd0;
      {reg_file_wr_en, wr_reg_mux_sel, op1_sel}         <= 3'd0;
      op2_sel        <= 2'b00;
      alu_demux      <= 2'b00;
      alu_ctrl       <= 5'd0;
      immediate      <= '0;
      memory_size    <= 2'b00;
      mem_unsigned   <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      curr_state     <= w_next_state;
      mem_req        <= (w_next_state == S_FETCH) || (w_next_state == S_MEM);
      mem_sel        <= (w_next_state == S_MEM);
      mem_wr_en      <= (w_next_state == S_MEM) && w_is_store;
      load_ir        <= (w_next_state == S_LOAD_IR);
      load_mdr       <= (w_next_state == S_LOAD_MDR);
      pc_update      <= (w_next_state == S_PC_WR);
      reg_file_wr_en <= (w_next_state == S_WB) || (w_next_state == S_LOAD_WR) ||
                        (w_next_state == S_LINK_WR);
      wr_reg_mux_sel <= (w_next_state == S_LOAD_WR);
      op1_sel        <= ((w_next_state == S_EXEC) && w_is_auipc) ||
                        (w_next_state == S_BR_TGT) || (w_next_state == S_LINK) ||
                        ((w_next_state == S_JUMP_TGT) && !w_is_jalr) ||
                        (w_next_state == S_PC_ADD);
      case (w_next_state)
        S_EXEC:     op2_sel <= w_is_r ? 2'b01 : 2'b10;
        S_BR_CMP:   op2_sel <= 2'b01;
        S_ADDR, S_BR_TGT, S_JUMP_TGT: op2_sel <= 2'b10;
        default:    op2_sel <= 2'b00;
      endcase
      case (w_next_state)
        S_EXEC, S_LINK: alu_demux <= 2'b01;
        S_ADDR:         alu_demux <= 2'b10;
        default:        alu_demux <= 2'b00;
      endcase
      alu_ctrl       <= ((w_next_state == S_EXEC) || (w_next_state == S_BR_CMP)) ? w_alu : 5'd0;
      if (curr_state == S_DECODE) begin
        immediate    <= XLEN'($signed(w_imm32));
        memory_size  <= instruction[13:12];
        mem_unsigned <= instruction[14];
      end
      mem_err        <= mem_err | w_wd_expire;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= illegal | ((curr_state == S_DECODE) && !w_legal);
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cntl_mc_hs.sv
//------------------------------------------------------------------------------
// tb_cntl_mc_hs : directed scoreboard bench for cntl_mc_hs (MEM_TO = 4)
// Revision      : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cntl_mc_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        bcond;
  logic        mem_ready;
  logic        mem_req, mem_sel, mem_wr_en, mem_unsigned;
  logic [1:0]  memory_size;
  logic        load_ir, load_mdr, pc_update, reg_file_wr_en, wr_reg_mux_sel, op1_sel;
  logic [1:0]  op2_sel, alu_demux;
  logic [4:0]  alu_ctrl;
  logic [31:0] immediate;
  logic        illegal, mem_err;
  logic [4:0]  curr_state;

  cntl_mc_hs #(.XLEN(32), .MEM_TO(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .bcond(bcond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_wr_en(mem_wr_en), .memory_size(memory_size), .mem_unsigned(mem_unsigned),
    .load_ir(load_ir), .load_mdr(load_mdr), .pc_update(pc_update),
    .reg_file_wr_en(reg_file_wr_en), .wr_reg_mux_sel(wr_reg_mux_sel),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_demux(alu_demux),
    .alu_ctrl(alu_ctrl), .immediate(immediate), .illegal(illegal),
    .mem_err(mem_err), .curr_state(curr_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic       rdy;
    logic       bc;
    logic [5:0] a;   // {check, alu_ctrl}
    logic [5:0] s;   // {check, op1_sel, op2_sel, alu_demux}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic is_store = 1'b0;

  localparam logic [5:0] NA = 6'd0;

  function automatic logic [5:0] A(input logic [4:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [5:0] S(input logic o1, input logic [1:0] o2, input logic [1:0] dm);
    return {1'b1, o1, o2, dm};
  endfunction

  function automatic void push(input logic [4:0] st, input logic rdy, input logic bc,
                               input logic [5:0] a, input logic [5:0] s);
    exp_t e;
    e.st = st; e.rdy = rdy; e.bc = bc; e.a = a; e.s = s;
    sb.push_back(e);
  endfunction

  function automatic void p(input logic [4:0] st);
    push(st, 1'b1, 1'b0, NA, NA);
  endfunction

  function automatic void push_fetch(input int waits);
    for (int i = 0; i < waits; i++) push(5'd0, 1'b0, 1'b0, NA, NA);
    push(5'd0, 1'b1, 1'b0, NA, NA);
    p(5'd1);
    p(5'd2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scoreboard entry per clock: drive handshake, compare, advance.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      bcond     = e.bc;
      chk("curr_state", curr_state, e.st);
      chk("mem_req", mem_req, (e.st == 5'd0) || (e.st == 5'd5));
      chk("mem_sel", mem_sel, e.st == 5'd5);
      chk("mem_wr_en", mem_wr_en, (e.st == 5'd5) && is_store);
      chk("load_ir", load_ir, e.st == 5'd1);
      chk("load_mdr", load_mdr, e.st == 5'd6);
      chk("pc_update", pc_update, e.st == 5'd15);
      chk("reg_file_wr_en", reg_file_wr_en, (e.st == 5'd7) || (e.st == 5'd8) || (e.st == 5'd12));
      if (reg_file_wr_en) chk("wr_reg_mux_sel", wr_reg_mux_sel, e.st == 5'd7);
      if (e.a[5]) chk("alu_ctrl", alu_ctrl, e.a[4:0]);
      if (e.s[5]) begin
        chk("op1_sel", op1_sel, e.s[4]);
        chk("op2_sel", op2_sel, e.s[3:2]);
        chk("alu_demux", alu_demux, e.s[1:0]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", curr_state, 5'd0);
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_strobes", {mem_sel, mem_wr_en, load_ir, load_mdr, pc_update, reg_file_wr_en}, 6'd0);
    chk("rst_alu_ctrl", alu_ctrl, 5'd0);
    chk("rst_immediate", immediate, 32'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    rst = 1'b0;
  endtask

  // R/I/U-class path after DECODE: EXEC, WB, PC_ADD, PC_WR.
  function automatic void push_exec(input logic [4:0] alu, input logic o1, input logic [1:0] o2);
    push(5'd3, 1'b1, 1'b0, A(alu), S(o1, o2, 2'b01));
    p(5'd8);
    push(5'd14, 1'b1, 1'b0, NA, S(1'b1, 2'b00, 2'b00));
    p(5'd15);
  endfunction

  initial begin
    rst = 1'b1; instruction = 32'h0000_0013; bcond = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // ADD x3,x1,x2
    instruction = 32'h002081B3; is_store = 1'b0;
    push_fetch(0); push_exec(5'b00000, 1'b0, 2'b01); drain();

    // SUB x3,x1,x2
    instruction = 32'h402081B3;
    push_fetch(0); push_exec(5'b01000, 1'b0, 2'b01); drain();

    // SRAI x1,x2,3
    instruction = 32'h40315093;
    push_fetch(0); push_exec(5'b01101, 1'b0, 2'b10); drain();
    chk("srai_imm", immediate, 32'h0000_0403);

    // SLTIU x1,x2,5 with two fetch wait cycles
    instruction = 32'h00513093;
    push_fetch(2); push_exec(5'b01011, 1'b0, 2'b10); drain();

    // LUI x5,0x80000
    instruction = 32'h800002B7;
    push_fetch(0); push_exec(5'b11000, 1'b0, 2'b10); drain();
    chk("lui_imm", immediate, 32'h8000_0000);

    // AUIPC x1,1
    instruction = 32'h00001097;
    push_fetch(0); push_exec(5'b00000, 1'b1, 2'b10); drain();
    chk("auipc_imm", immediate, 32'h0000_1000);

    // LW x5,-4(x1), three MEM wait cycles (one short of the watchdog)
    instruction = 32'hFFC0A283;
    push_fetch(0);
    push(5'd4, 1'b1, 1'b0, A(5'd0), S(1'b0, 2'b10, 2'b10));
    for (int i = 0; i < 3; i++) push(5'd5, 1'b0, 1'b0, NA, NA);
    push(5'd5, 1'b1, 1'b0, NA, NA);
    p(5'd6); p(5'd7); p(5'd14); p(5'd15);
    chk("lw_entries", sb.size(), 12);
    drain();
    chk("lw_imm", immediate, 32'hFFFF_FFFC);
    chk("lw_size", memory_size, 2'b10);
    chk("lw_unsigned", mem_unsigned, 1'b0);

    // SW x2,8(x1), one fetch wait
    instruction = 32'h0020A423; is_store = 1'b1;
    push_fetch(1);
    push(5'd4, 1'b1, 1'b0, NA, S(1'b0, 2'b10, 2'b10));
    p(5'd5); p(5'd14); p(5'd15);
    drain();
    chk("sw_imm", immediate, 32'd8);
    is_store = 1'b0;

    // BEQ x1,x2,+16 taken
    instruction = 32'h00208863;
    push_fetch(0);
    push(5'd9, 1'b1, 1'b1, A(5'b10000), S(1'b0, 2'b01, 2'b00));
    push(5'd10, 1'b1, 1'b0, NA, S(1'b1, 2'b10, 2'b00));
    p(5'd15);
    drain();
    chk("beq_imm", immediate, 32'd16);

    // BEQ not taken
    push_fetch(0);
    push(5'd9, 1'b1, 1'b0, A(5'b10000), S(1'b0, 2'b01, 2'b00));
    push(5'd14, 1'b1, 1'b1, NA, S(1'b1, 2'b00, 2'b00));
    p(5'd15);
    drain();

    // JALR x1,8(x2)
    instruction = 32'h008100E7;
    push_fetch(0);
    push(5'd11, 1'b1, 1'b0, NA, S(1'b1, 2'b00, 2'b01));
    p(5'd12);
    push(5'd13, 1'b1, 1'b0, NA, S(1'b0, 2'b10, 2'b00));
    p(5'd15);
    drain();
    chk("jalr_imm", immediate, 32'd8);

    // JAL x0,-4
    instruction = 32'hFFDFF06F;
    push_fetch(0);
    push(5'd11, 1'b1, 1'b0, NA, S(1'b1, 2'b00, 2'b01));
    p(5'd12);
    push(5'd13, 1'b1, 1'b0, NA, S(1'b1, 2'b10, 2'b00));
    p(5'd15);
    drain();
    chk("jal_imm", immediate, 32'hFFFF_FFFC);

    // Illegal opcode
    instruction = 32'h0000007F;
    push_fetch(0);
`ifdef ILLEGAL_TRAP_EN
    push(5'd16, 1'b1, 1'b0, NA, NA);
    push(5'd16, 1'b1, 1'b0, NA, NA);
    drain();
    chk("illegal_set", illegal, 1'b1);
    do_reset();
`else
    p(5'd14); p(5'd15);
    drain();
    chk("illegal_tied", illegal, 1'b0);
`endif

    // Watchdog: four fetch waits expire into TRAP, held until reset
    instruction = 32'h002081B3;
    for (int i = 0; i < 4; i++) push(5'd0, 1'b0, 1'b0, NA, NA);
    for (int i = 0; i < 3; i++) push(5'd16, 1'b1, 1'b0, NA, NA);
    drain();
    chk("trap_mem_err", mem_err, 1'b1);
    chk("trap_strobes", {op1_sel, op2_sel, alu_demux, alu_ctrl}, 10'd0);
    do_reset();
    push_fetch(0); push_exec(5'b00000, 1'b0, 2'b01); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
